// File: rtl/seq_div_unit_if.sv
// Operand/result bundle between the CPU control path and the divider.
`timescale 1ns/1ps
interface seq_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output a, b, start,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  a, b, start,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_div_unit.sv
// Restoring signed divider, one quotient bit per clock, MIPS DIV results.
`timescale 1ns/1ps
module seq_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    seq_div_unit_if.slave dif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        ZERO,
        DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rmdr_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH-1:0] abs_a_d;
    logic [WIDTH-1:0] abs_b_d;
    logic [WIDTH:0]   cand_d;
    logic [WIDTH:0]   diff_d;
    logic [WIDTH-1:0] q_fix_d;
    logic [WIDTH-1:0] r_fix_d;

    // -MIN wraps back to MIN, which is the correct unsigned magnitude
    assign abs_a_d = dif.a[WIDTH-1] ? -dif.a : dif.a;
    assign abs_b_d = dif.b[WIDTH-1] ? -dif.b : dif.b;

    assign cand_d  = {rem_q, dq_q[WIDTH-1]};
    assign diff_d  = cand_d - {1'b0, dvs_q};

    assign q_fix_d = neg_q_q ? -dq_q  : dq_q;
    assign r_fix_d = neg_r_q ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dvs_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            quot_q  <= '0;
            rmdr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dif.start) begin
                        neg_q_q <= dif.a[WIDTH-1] ^ dif.b[WIDTH-1];
                        neg_r_q <= dif.a[WIDTH-1];
                        dq_q    <= abs_a_d;
                        dvs_q   <= abs_b_d;
                        rem_q   <= '0;
                        cnt_q   <= CW'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= (dif.b == '0) ? ZERO : CALC;
                    end
                end
                CALC: begin
                    // dq_q shifts dividend bits out and quotient bits in
                    if (!diff_d[WIDTH]) begin
                        rem_q <= diff_d[WIDTH-1:0];
                        dq_q  <= {dq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= cand_d[WIDTH-1:0];
                        dq_q  <= {dq_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quot_q  <= q_fix_d;
                    rmdr_q  <= r_fix_d;
                    done_q  <= 1'b1;
                    dbz_q   <= 1'b0;
                    state_q <= DONE;
                end
                ZERO: begin
                    done_q  <= 1'b1;
                    dbz_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dif.busy        = busy_q;
    assign dif.done        = done_q;
    assign dif.div_by_zero = dbz_q;
    assign dif.quotient    = quot_q;
    assign dif.remainder   = rmdr_q;
endmodule

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Iterative signed 32-bit divider for the multicycle CPU's DIV instruction path.
- Sits between register-file read ports A/B and the HI/LO register pair. The control unit pulses start, waits on done, then commits quotient→LO and remainder→HI.
- Restoring algorithm, one quotient bit per clock; MIPS DIV semantics.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted
- a  input  WIDTH  dividend (rs), two's complement
- b  input  WIDTH  divisor (rt), two's complement
- start  input  1  request; sampled only in IDLE
- busy  output  1  high from accepted start until done cycle ends
- done  output  1  one-cycle pulse, results valid
- div_by_zero  output  1  valid with done; high when b was 0
- quotient  output  WIDTH  signed quotient (to LO)
- remainder  output  WIDTH  signed remainder (to HI)

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; internal counter/working regs = 0. Applies immediately, including mid-operation. No partial results survive.
- States: IDLE, CALC, FIX, ZERO, DONE.
- IDLE, start=1 at edge E0 (acceptance):
  - Latch sign_q = a[31]^b[31] and sign_r = a[31].
  - Latch |a| and |b| as unsigned WIDTH-bit magnitudes; |0x80000000| = 0x80000000.
  - Clear partial remainder; counter = WIDTH-1.
  - If b==0, go to ZERO; else go to CALC.
- CALC, one step per edge:
  - Shift {rem,dq} left 1.
  - Trial-subtract |b| from the rem candidate using a WIDTH+1-bit subtract.
  - If non-negative, keep the difference and set q bit = 1; else restore and set q bit = 0.
  - Counter decrements. After WIDTH steps (edges E1..E32), go to FIX.
- FIX (edge E33):
  - quotient <= sign_q ? -q : q; remainder <= sign_r ? -r : r.
  - done=1, div_by_zero=0, state=DONE.
  - Truncation toward zero; remainder takes the dividend's sign.
  - 0x80000000 / -1 wraps to quotient 0x80000000, remainder 0, no flag.
- ZERO (edge E1): done=1, div_by_zero=1; quotient/remainder hold previous values; state=DONE.
- DONE: done and flag stay high exactly one cycle. Next edge clears done and div_by_zero and returns to IDLE.
- Latency: done high in the cycle after E33 for normal divides, or after E1 for divide-by-zero.
- Back-to-back: a start is accepted in the IDLE cycle following DONE, never in DONE itself.
- busy: 1 in CALC, FIX, ZERO, DONE; 0 in IDLE.
- Operand changes after E0 are ignored. start while busy is ignored (not queued).
- quotient/remainder are registered and hold their last value until the next FIX or reset.

Test Plan:
- a=7, b=2, start pulse → done exactly 33 edges after acceptance; quotient=3, remainder=1, div_by_zero=0, busy falls the cycle after done.
- a=0xFFFFFFF9 (-7), b=2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also a=7, b=0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- a=0x80000000, b=0xFFFFFFFF → quotient=0x80000000, remainder=0, div_by_zero=0. Also a=0x7FFFFFFF, b=1 → quotient=0x7FFFFFFF, remainder=0.
- Prior result q=3/r=1, then a=5, b=0 → done and div_by_zero high one cycle, 1 edge after acceptance; quotient=3, remainder=1 unchanged.
- Start a=100, b=7; change a/b and pulse start at edge 10 → ignored; result quotient=14, remainder=2 at edge 33.
- reset driven low at edge 15 of a divide → outputs 0 immediately, busy=0. After release, start a=9, b=3 → quotient=3, remainder=0 with normal latency.
